mesh_seq_solver: RTL

MESH_SEQ_SOLVER -- requirements
Module: mesh_seq_solver

---
 rtl/mesh_seq_solver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mesh_seq_solver.sv
// mesh_seq_solver: sequential 2-D mesh (membrane) wave solver.
// Two node banks (cur/prev) are updated one node per cycle in raster order; each
// completed pass over the mesh yields one tap sample on a valid/ready handshake.
// Ports:
//   clk, reset (async, active-low)
//   start / stop           : begin a new strike / end after the current step
//   strike_amp/x/y         : initial displacement and struck node
//   tap_x/y                : node whose updated value is emitted
//   rho, eta_shift         : coupling coefficient and damping shift
//   out, out_valid, out_ready : tap sample handshake
//   busy, step_count       : activity flag and completed steps since start
module mesh_seq_solver #(
    parameter int unsigned XSIZE = 16,
    parameter int unsigned YSIZE = 16,
    parameter int unsigned W     = 18,
    parameter int unsigned FRAC  = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic signed [W-1:0] strike_amp,
    input  logic [7:0]          strike_x,
    input  logic [7:0]          strike_y,
    input  logic [7:0]          tap_x,
    input  logic [7:0]          tap_y,
    input  logic signed [W-1:0] rho,
    input  logic [3:0]          eta_shift,
    output logic signed [W-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [15:0]         step_count
);

    localparam int unsigned NODES = XSIZE * YSIZE;
    localparam int unsigned XW    = (XSIZE > 1) ? $clog2(XSIZE) : 1;
    localparam int unsigned YW    = (YSIZE > 1) ? $clog2(YSIZE) : 1;
    localparam int unsigned IW    = (NODES > 1) ? $clog2(NODES) : 1;
    // Wide enough for rho*lap plus the update terms without loss
    localparam int unsigned BW    = 2 * W + 8;

    typedef enum logic [1:0] {IDLE, STRIKE, RUN, EMIT} state_t;

    state_t state, state_d;

    logic signed [W-1:0] mem [2][NODES];
    logic                bank_sel;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [IW-1:0]       idx_q;
    logic                stop_q;

    logic signed [W-1:0] amp_q, rho_q;
    logic [7:0]          sx_q, sy_q, tx_q, ty_q;
    logic [3:0]          eta_q;

    logic signed [W-1:0]  u_v, p_v, n_v, s_v, e_v, w_v, u_next;
    logic signed [BW-1:0] lap_w, prod_w, b_w, un_w;
    logic                 last_node, strike_hit, tap_hit;

    assign last_node  = (idx_q == IW'(NODES - 1));
    assign strike_hit = (8'(x_q) == sx_q) && (8'(y_q) == sy_q);
    assign tap_hit    = (8'(x_q) == tx_q) && (8'(y_q) == ty_q);

    // Node and neighbour fetch; neighbours beyond the mesh edge read as zero
    always_comb begin
        u_v = mem[bank_sel][idx_q];
        p_v = mem[~bank_sel][idx_q];
        n_v = '0;
        s_v = '0;
        e_v = '0;
        w_v = '0;
        if (y_q != '0)                 n_v = mem[bank_sel][idx_q - IW'(XSIZE)];
        if (32'(y_q) != YSIZE - 1)     s_v = mem[bank_sel][idx_q + IW'(XSIZE)];
        if (x_q != '0)                 w_v = mem[bank_sel][idx_q - IW'(1)];
        if (32'(x_q) != XSIZE - 1)     e_v = mem[bank_sel][idx_q + IW'(1)];
    end

    // Damped wave update with saturation to the W-bit signed range
    always_comb begin
        lap_w  = BW'(n_v) + BW'(s_v) + BW'(e_v) + BW'(w_v) - (BW'(u_v) <<< 2);
        prod_w = BW'(rho_q) * lap_w;
        b_w    = (prod_w >>> FRAC) + (BW'(u_v) <<< 1) - BW'(p_v) + (BW'(p_v) >>> eta_q);
        un_w   = b_w - (b_w >>> eta_q);
        u_next = un_w[W-1:0];
        if (un_w[BW-1:W-1] != {(BW-W+1){un_w[BW-1]}})
            u_next = un_w[BW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = STRIKE;
            STRIKE:  if (last_node) state_d = RUN;
            RUN:     if (last_node) state_d = EMIT;
            EMIT:    if (out_ready) state_d = (stop_q || stop) ? IDLE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Datapath, node banks and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NODES; i++) begin
                mem[0][i] <= '0;
                mem[1][i] <= '0;
            end
            bank_sel   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            amp_q      <= '0;
            rho_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            eta_q      <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            step_count <= '0;
        end else begin
            out_valid <= (state_d == EMIT);
            busy      <= (state_d != IDLE);

            // Stop is remembered until the block returns to IDLE
            if (state_d == IDLE)            stop_q <= 1'b0;
            else if (state != IDLE && stop) stop_q <= 1'b1;

            if (state == IDLE && start) begin
                amp_q      <= strike_amp;
                rho_q      <= rho;
                sx_q       <= strike_x;
                sy_q       <= strike_y;
                tx_q       <= tap_x;
                ty_q       <= tap_y;
                eta_q      <= eta_shift;
                step_count <= '0;
                out        <= '0;
                x_q        <= '0;
                y_q        <= '0;
                idx_q      <= '0;
            end

            if (state == STRIKE) begin
                mem[bank_sel][idx_q]  <= strike_hit ? amp_q : '0;
                mem[~bank_sel][idx_q] <= '0;
            end

            if (state == RUN) begin
                mem[~bank_sel][idx_q] <= u_next;
                if (tap_hit) out <= u_next;
                if (last_node) begin
                    bank_sel   <= ~bank_sel;
                    step_count <= step_count + 16'd1;
                end
            end

            // Raster walk shared by STRIKE and RUN
            if (state == STRIKE || state == RUN) begin
                if (last_node) begin
                    x_q   <= '0;
                    y_q   <= '0;
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + IW'(1);
                    if (32'(x_q) == XSIZE - 1) begin
                        x_q <= '0;
                        y_q <= y_q + YW'(1);
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                end
            end
        end
    end

endmodule
